rvfi_check_seq: RTL and testbench



---
 rtl/rvfi_seq_pkg.sv | 31 +++
 rtl/rvfi_popcount.sv | 28 ++
 rtl/rvfi_check_seq.sv | 128 ++++++++++++
 tb/tb_rvfi_check_seq.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/rvfi_seq_pkg.sv
// Shared types and helpers for the RVFI checker sequencer.
// Combinational content only; no latency.
// No flow control; consumed at elaboration time.
package rvfi_seq_pkg;

   // Sequencer phases: checker reset, pre-trigger run, wait-for-check, finished.
   typedef enum logic [1:0] {
      S_RST  = 2'd0,
      S_RUN  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } seq_state_e;

   // Default counter width and the value a counter of that width saturates at.
   localparam int unsigned SEQ_CNT_W  = 8;
   localparam logic [SEQ_CNT_W-1:0] RETIRE_SAT = '1;

   // Widest retire vector the popcount helper accepts.
   localparam int unsigned POP_MAX_W  = 32;

   // Number of set bits in a (zero-extended) retire vector.
   function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < POP_MAX_W; i++) begin
         n += 32'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/rvfi_popcount.sv
// Counts asserted retire strobes across all RVFI channels.
// Purely combinational, zero latency.
// No backpressure.
module rvfi_popcount
   import rvfi_seq_pkg::*;
#(
   parameter int unsigned NRET = 1
) (
   input  logic [NRET-1:0]             valid_i,
   output logic [$clog2(NRET+1)-1:0]   count_o
);

   localparam int unsigned CW = $clog2(NRET + 1);

   if (NRET < 1 || NRET > POP_MAX_W) begin : g_nret_err
      $fatal(1, "rvfi_popcount: NRET out of range");
   end

   logic [POP_MAX_W-1:0] valid_ext;

   // Widen to the helper's fixed width, then narrow the result back down.
   always_comb begin
      valid_ext = '0;
      valid_ext[NRET-1:0] = valid_i;
      count_o   = CW'(popcount(valid_ext));
   end

endmodule

// File: rtl/rvfi_check_seq.sv
// Sequences checker reset/trig/check strobes on a fixed cycle schedule and counts retirements.
// All outputs are decoded from registers; retire_count reflects rvfi_valid one edge later.
// No backpressure; rvfi_valid is observed, never stalled.
// Optional: RISCV_FORMAL_SEQ_TRIG_ON_RETIRE_EN moves trig to the first retirement at/after TRIG_CYCLE.
module rvfi_check_seq
   import rvfi_seq_pkg::*;
#(
   parameter int unsigned NRET         = 1,
   parameter int unsigned CNT_W        = SEQ_CNT_W,
   parameter int unsigned RESET_CYCLES = 1,
   parameter int unsigned TRIG_CYCLE   = 10,
   parameter int unsigned CHECK_CYCLE  = 20
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic [NRET-1:0]   rvfi_valid,
   output logic              chk_reset,
   output logic              trig,
   output logic              check,
   output logic              done,
   output logic [CNT_W-1:0]  cycle,
   output logic [CNT_W-1:0]  retire_count,
   output logic              trig_timeout
);

   localparam int unsigned PCW = $clog2(NRET + 1);
   // Saturation value at this instance's width, carried with a spare top bit.
   localparam logic [CNT_W:0] SAT_EXT = {1'b0, {CNT_W{1'b1}}};

   // The schedule must be ordered and the frozen cycle value must fit without wrapping.
   if (!(RESET_CYCLES >= 1 && TRIG_CYCLE >= RESET_CYCLES &&
         CHECK_CYCLE > TRIG_CYCLE && CHECK_CYCLE < (2**CNT_W) - 1)) begin : g_param_err
      $fatal(1, "rvfi_check_seq: illegal RESET_CYCLES/TRIG_CYCLE/CHECK_CYCLE/CNT_W");
   end

   seq_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cycle_q, cycle_d;
   logic [CNT_W-1:0]  retire_q, retire_d;
   logic [PCW-1:0]    pop_cnt;
   logic [CNT_W:0]    retire_sum;
   logic              trig_int;
   logic              check_int;

   rvfi_popcount #(.NRET(NRET)) u_popcount (
      .valid_i (rvfi_valid),
      .count_o (pop_cnt)
   );

   assign check_int = (state_q == S_WAIT) && (cycle_q == CNT_W'(CHECK_CYCLE));

`ifdef RISCV_FORMAL_SEQ_TRIG_ON_RETIRE_EN
   // Registered "a retirement was just sampled" so trig never depends on rvfi_valid combinationally.
   logic ret_seen_q, ret_seen_d;
   logic trig_to_q, trig_to_d;
   logic at_limit;

   assign at_limit = (cycle_q == CNT_W'(CHECK_CYCLE - 1));

   // Trigger on the first sampled retirement in the window, or force it on the last pre-check cycle.
   always_comb begin
      trig_int   = (state_q == S_RUN) && (cycle_q >= CNT_W'(TRIG_CYCLE)) &&
                   (ret_seen_q || at_limit);
      ret_seen_d = (state_q != S_RST) && (|rvfi_valid);
      trig_to_d  = trig_to_q | ((state_q == S_RUN) && at_limit && !ret_seen_q);
   end

   // Retirement sample and sticky timeout flag.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         ret_seen_q <= 1'b0;
         trig_to_q  <= 1'b0;
      end else begin
         ret_seen_q <= ret_seen_d;
         trig_to_q  <= trig_to_d;
      end
   end

   assign trig_timeout = trig_to_q;
`else
   assign trig_int     = (state_q == S_RUN) && (cycle_q == CNT_W'(TRIG_CYCLE));
   assign trig_timeout = 1'b0;
`endif

   // Next-state, cycle advance and saturating retire accumulation.
   always_comb begin
      state_d    = state_q;
      cycle_d    = cycle_q;
      retire_d   = retire_q;
      retire_sum = {1'b0, retire_q} + (CNT_W+1)'(pop_cnt);

      case (state_q)
         S_RST:   if (cycle_q == CNT_W'(RESET_CYCLES - 1)) state_d = S_RUN;
         S_RUN:   if (trig_int)  state_d = S_WAIT;
         S_WAIT:  if (check_int) state_d = S_DONE;
         S_DONE:  state_d = S_DONE;
         default: state_d = S_RST;
      endcase

      // The counter freezes once the schedule is over, so it cannot wrap.
      if (state_q != S_DONE) cycle_d = cycle_q + CNT_W'(1);

      // Retirements during checker reset are not part of the observed run.
      if (state_q != S_RST) begin
         retire_d = (retire_sum > SAT_EXT) ? SAT_EXT[CNT_W-1:0] : retire_sum[CNT_W-1:0];
      end
   end

   // State and counter registers.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_RST;
         cycle_q  <= '0;
         retire_q <= '0;
      end else begin
         state_q  <= state_d;
         cycle_q  <= cycle_d;
         retire_q <= retire_d;
      end
   end

   assign chk_reset    = (state_q == S_RST);
   assign trig         = trig_int;
   assign check        = check_int;
   assign done         = (state_q == S_DONE);
   assign cycle        = cycle_q;
   assign retire_count = retire_q;

endmodule

// File: tb/tb_rvfi_check_seq.sv
// Self-checking bench for rvfi_check_seq (NRET=2, default schedule).
// Drives inputs 1 time unit after each rising edge and checks all outputs there.
// Reference model tracks elapsed cycles and retirements as plain integers.
module tb_rvfi_check_seq;

   localparam int RC = 1;
   localparam int TC = 10;
   localparam int CC = 20;
   localparam int SATV = 255;

   logic       clock = 1'b0;
   logic       resetn;
   logic [1:0] rvfi_valid;
   logic       chk_reset, trig, check, done, trig_timeout;
   logic [7:0] cycle, retire_count;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state
   int k;          // cycles since release
   int rc;         // retirements counted
   bit last_ret;   // a counted retirement was sampled on the edge that produced cycle k
   bit trig_fired;
   bit to_flag;
   int n_trig_obs, n_check_obs, obs_trig_k;

   rvfi_check_seq #(
      .NRET(2), .CNT_W(8), .RESET_CYCLES(RC), .TRIG_CYCLE(TC), .CHECK_CYCLE(CC)
   ) dut (
      .clock        (clock),
      .resetn       (resetn),
      .rvfi_valid   (rvfi_valid),
      .chk_reset    (chk_reset),
      .trig         (trig),
      .check        (check),
      .done         (done),
      .cycle        (cycle),
      .retire_count (retire_count),
      .trig_timeout (trig_timeout)
   );

   always #5 clock = ~clock;

   task automatic cmp(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d (k=%0d)", tag, obs, exp, k);
      end
   endtask

   task automatic model_reset();
      k = 0; rc = 0; last_ret = 0; trig_fired = 0; to_flag = 0;
      n_trig_obs = 0; n_check_obs = 0; obs_trig_k = -1;
   endtask

   task automatic check_all(input string tag);
      bit e_trig;
`ifdef RISCV_FORMAL_SEQ_TRIG_ON_RETIRE_EN
      e_trig = !trig_fired && k >= TC && k <= CC - 1 && (last_ret || k == CC - 1);
`else
      e_trig = (k == TC);
`endif
      cmp({tag, ".chk_reset"}, int'(chk_reset), int'(k < RC));
      cmp({tag, ".trig"}, int'(trig), int'(e_trig));
      cmp({tag, ".check"}, int'(check), int'(k == CC));
      cmp({tag, ".done"}, int'(done), int'(k > CC));
      cmp({tag, ".cycle"}, int'(cycle), (k > CC) ? CC + 1 : k);
      cmp({tag, ".retire_count"}, int'(retire_count), rc);
      cmp({tag, ".trig_timeout"}, int'(trig_timeout), int'(to_flag));
      if (trig === 1'b1) begin n_trig_obs++; obs_trig_k = k; end
      if (check === 1'b1) n_check_obs++;
      if (e_trig) begin
         trig_fired = 1;
`ifdef RISCV_FORMAL_SEQ_TRIG_ON_RETIRE_EN
         if (!last_ret) to_flag = 1;
`endif
      end
   endtask

   // One clock: present v, let the edge happen, advance the model, check outputs.
   task automatic tick(input logic [1:0] v, input string tag);
      rvfi_valid = v;
      @(posedge clock);
      if (k >= RC) rc = (rc + $countones(v) > SATV) ? SATV : rc + $countones(v);
      last_ret = (k >= RC) && (v != 2'b00);
      k++;
      #1;
      check_all(tag);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      #1;
      model_reset();
      check_all("rst_async");
      @(posedge clock);
      @(posedge clock);
      #1;
      check_all("rst_hold");
      resetn = 1'b1;
      check_all("rel_c0");
   endtask

   task automatic end_epoch(input string tag);
      cmp({tag, ".trig_pulses"}, n_trig_obs, 1);
      cmp({tag, ".check_pulses"}, n_check_obs, 1);
   endtask

   initial begin
      resetn     = 1'b0;
      rvfi_valid = 2'b00;
      model_reset();
      @(posedge clock);
      #1;

      // Idle schedule, no retirements.
      do_reset();
      for (int i = 0; i < 25; i++) tick(2'b00, "idle");
      end_epoch("idle");
      cmp("idle.trig_cycle", obs_trig_k,
`ifdef RISCV_FORMAL_SEQ_TRIG_ON_RETIRE_EN
          CC - 1
`else
          TC
`endif
      );

      // Random retirements, reset pulled mid-schedule at cycle 15.
      do_reset();
      for (int i = 0; i < 15; i++) tick(2'($urandom_range(0, 3)), "pre_abort");
      cmp("abort.check_pulses", n_check_obs, 0);
      resetn = 1'b0;
      #1;
      model_reset();
      check_all("abort_async");
      @(posedge clock);
      #1;
      check_all("abort_hold");
      resetn = 1'b1;
      for (int i = 0; i < 25; i++) tick(2'($urandom_range(0, 3)), "post_abort");
      end_epoch("post_abort");

      // Single retirement sampled on the edge producing cycle 13.
      do_reset();
      for (int i = 1; i <= 25; i++) tick((i == 13) ? 2'b01 : 2'b00, "ret13");
      end_epoch("ret13");
      cmp("ret13.trig_cycle", obs_trig_k,
`ifdef RISCV_FORMAL_SEQ_TRIG_ON_RETIRE_EN
          13
`else
          TC
`endif
      );
      cmp("ret13.timeout", int'(trig_timeout), 0);

      // Both channels retire every cycle: +2 per cycle, saturating at 255.
      do_reset();
      for (int i = 0; i < 140; i++) tick(2'b11, "sat");
      cmp("sat.value", int'(retire_count), SATV);
      for (int i = 0; i < 6; i++) tick(2'($urandom_range(1, 3)), "sat_hold");
      end_epoch("sat");

      // Random traffic, fully model-checked.
      for (int e = 0; e < 3; e++) begin
         do_reset();
         for (int i = 0; i < 30; i++) tick(2'($urandom_range(0, 3) & $urandom_range(0, 3)), "rand");
         end_epoch("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
